// File: rtl/amo_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : amo_sequencer_if
//  Description : Bundle of the request, memory, ALU and snoop signals that
//                connect the atomic-op sequencer to its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface amo_sequencer_if #(
    parameter int XLEN = 32
);
    // Request side
    logic            start_i;
    logic [4:0]      funct5_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] src_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] rd_data_o;
    // Memory side
    logic            mem_read_o;
    logic            mem_write_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_ready_i;
    // Shared ALU
    logic [5:0]      alu_op_o;
    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [XLEN-1:0] alu_result_i;
    // Stores by other masters
    logic            snoop_valid_i;
    logic [XLEN-1:0] snoop_addr_i;

    // Environment view: issues requests, models memory/ALU/snoops
    modport master (
        output start_i, funct5_i, addr_i, src_i,
        input  busy_o, done_o, rd_data_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i,
        input  alu_op_o, alu_a_o, alu_b_o,
        output alu_result_i,
        output snoop_valid_i, snoop_addr_i
    );

    // Sequencer view
    modport slave (
        input  start_i, funct5_i, addr_i, src_i,
        output busy_o, done_o, rd_data_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i,
        output alu_op_o, alu_a_o, alu_b_o,
        input  alu_result_i,
        input  snoop_valid_i, snoop_addr_i
    );
endinterface
`default_nettype wire

// File: rtl/amo_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : amo_sequencer
//  Description : Sequences RISC-V LR/SC and AMO read-modify-write operations
//                over a single-port memory, using a shared ALU, and tracks
//                the LR reservation including kills by external stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module amo_sequencer #(
    parameter int XLEN = 32
) (
    input  wire logic    clk_i,
    input  wire logic    reset_i,
    amo_sequencer_if.slave bus
);

    localparam logic [4:0] c_f5_add  = 5'b00000;
    localparam logic [4:0] c_f5_swap = 5'b00001;
    localparam logic [4:0] c_f5_lr   = 5'b00010;
    localparam logic [4:0] c_f5_sc   = 5'b00011;
    localparam logic [4:0] c_f5_xor  = 5'b00100;
    localparam logic [4:0] c_f5_or   = 5'b01000;
    localparam logic [4:0] c_f5_and  = 5'b01100;
    localparam logic [4:0] c_f5_min  = 5'b10000;
    localparam logic [4:0] c_f5_max  = 5'b10100;
    localparam logic [4:0] c_f5_minu = 5'b11000;
    localparam logic [4:0] c_f5_maxu = 5'b11100;

    localparam logic [5:0] c_alu_add  = 6'b000010;
    localparam logic [5:0] c_alu_xor  = 6'b000101;
    localparam logic [5:0] c_alu_and  = 6'b000000;
    localparam logic [5:0] c_alu_or   = 6'b000001;
    localparam logic [5:0] c_alu_min  = 6'b100000;
    localparam logic [5:0] c_alu_max  = 6'b100001;
    localparam logic [5:0] c_alu_minu = 6'b100010;
    localparam logic [5:0] c_alu_maxu = 6'b100011;

    // Masking (rather than slicing) keeps every address bit referenced
    localparam logic [XLEN-1:0] c_word_mask = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] c_one       = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      funct5_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] loaded_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [XLEN-1:0] rd_data_q;
    logic            resv_valid_q, resv_valid_d;
    logic [XLEN-1:0] resv_addr_q, resv_addr_d;

    logic            w_is_lr;
    logic            w_is_sc;
    logic            w_start_sc;
    logic [XLEN-1:0] w_start_word;
    logic [XLEN-1:0] w_snoop_word;
    logic            w_sc_ok;
    logic [XLEN-1:0] w_result;
    logic [5:0]      w_alu_op;

    assign w_is_lr      = (funct5_q == c_f5_lr);
    assign w_is_sc      = (funct5_q == c_f5_sc);
    assign w_start_sc   = (bus.funct5_i == c_f5_sc);
    assign w_start_word = bus.addr_i & c_word_mask;
    assign w_snoop_word = bus.snoop_addr_i & c_word_mask;

    // An SC succeeds only against a live reservation on the same word that
    // is not being killed by a snoop in the very cycle the SC is accepted
    assign w_sc_ok = resv_valid_q && (resv_addr_q == w_start_word) &&
                     !(bus.snoop_valid_i && (w_snoop_word == w_start_word));

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (w_start_sc) state_d = w_sc_ok ? S_WRITE : S_DONE;
                    else            state_d = S_READ;
                end
            end
            S_READ:  if (bus.mem_ready_i) state_d = w_is_lr ? S_DONE : S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: if (bus.mem_ready_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU control is only meaningful in EXEC; add is the idle encoding
    always_comb begin
        w_alu_op = c_alu_add;
        if (state_q == S_EXEC) begin
            case (funct5_q)
                c_f5_xor:  w_alu_op = c_alu_xor;
                c_f5_and:  w_alu_op = c_alu_and;
                c_f5_or:   w_alu_op = c_alu_or;
                c_f5_min:  w_alu_op = c_alu_min;
                c_f5_max:  w_alu_op = c_alu_max;
                c_f5_minu: w_alu_op = c_alu_minu;
                c_f5_maxu: w_alu_op = c_alu_maxu;
                default:   w_alu_op = c_alu_add;
            endcase
        end
    end

    // Value returned in rd, selected by the state that leads into DONE
    always_comb begin
        w_result = loaded_q;
        case (state_q)
            S_READ:  w_result = bus.mem_rdata_i;               // LR
            S_IDLE:  w_result = c_one;                         // failed SC
            S_WRITE: w_result = w_is_sc ? '0 : loaded_q;       // SC ok / AMO
            default: w_result = loaded_q;
        endcase
    end

    // Operand latches, loaded word, store data and rd result
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            funct5_q    <= '0;
            src_q       <= '0;
            mem_addr_q  <= '0;
            loaded_q    <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            if (state_q == S_IDLE && bus.start_i) begin
                funct5_q   <= bus.funct5_i;
                src_q      <= bus.src_i;
                mem_addr_q <= w_start_word;
                if (w_start_sc && w_sc_ok) mem_wdata_q <= bus.src_i;
            end
            if (state_q == S_READ && bus.mem_ready_i) loaded_q <= bus.mem_rdata_i;
            if (state_q == S_EXEC) begin
                mem_wdata_q <= (funct5_q == c_f5_swap) ? src_q : bus.alu_result_i;
            end
            if (state_d == S_DONE && state_q != S_DONE) rd_data_q <= w_result;
        end
    end

    // Reservation next value: kills first, then an LR set unless snooped
    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        if (state_q == S_IDLE && bus.start_i && w_start_sc) resv_valid_d = 1'b0;
        if (state_q == S_WRITE && bus.mem_ready_i && (mem_addr_q == resv_addr_q)) begin
            resv_valid_d = 1'b0;
        end
        if (bus.snoop_valid_i && (w_snoop_word == resv_addr_q)) resv_valid_d = 1'b0;
        if (state_q == S_READ && bus.mem_ready_i && w_is_lr &&
            !(bus.snoop_valid_i && (w_snoop_word == mem_addr_q))) begin
            resv_valid_d = 1'b1;
            resv_addr_d  = mem_addr_q;
        end
    end

    // Reservation register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end

    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.rd_data_o   = rd_data_q;
    assign bus.mem_read_o  = (state_q == S_READ);
    assign bus.mem_write_o = (state_q == S_WRITE);
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.alu_op_o    = w_alu_op;
    assign bus.alu_a_o     = loaded_q;
    assign bus.alu_b_o     = src_q;

endmodule
`default_nettype wire

// File: doc/amo_sequencer.md
AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to start one atomic op; sampled only in IDLE.
REQ-005 funct5  input  5  atomic selector (instruction func7[6:2]).
REQ-006 addr  input  XLEN  effective address (rs1).
REQ-007 src  input  XLEN  operand (rs2).
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 done  output  1  one-cycle pulse at op completion.
REQ-010 rd_data  output  XLEN  result for rd; valid while done=1, held until next done.
REQ-011 mem_read  output  1  memory read request.
REQ-012 mem_write  output  1  memory write request.
REQ-013 mem_addr  output  XLEN  {addr[XLEN-1:2],2'b00}, latched at start.
REQ-014 mem_wdata  output  XLEN  store data.
REQ-015 mem_rdata  input  XLEN  read data, valid when mem_ready=1 with mem_read.
REQ-016 mem_ready  input  1  completes the pending read or write on the rising edge where it is high.
REQ-017 alu_op  output  6  ALU control code driven to the shared ALU.
REQ-018 alu_a / alu_b  output  XLEN each  ALU operands: loaded word and latched src.
REQ-019 alu_result  input  XLEN  combinational ALU result.
REQ-020 snoop_valid / snoop_addr  input  1 / XLEN  store by another master, used for reservation kill.

Function
REQ-021 States SHALL be IDLE, READ, EXEC, WRITE, DONE; start in IDLE latches addr, src, funct5.
REQ-022 LR (00010): IDLE->READ; on mem_ready capture mem_rdata, set reservation to word address, ->DONE; rd_data=loaded word.
REQ-023 SC (00011): at start, success if reservation valid, word address matches, no matching snoop that cycle; success ->WRITE (mem_wdata=src), rd_data=0; failure ->DONE, rd_data=1, no memory access.
REQ-024 Every SC SHALL clear the reservation whether it succeeds or fails.
REQ-025 AMO ops: IDLE->READ->EXEC->WRITE->DONE; rd_data = loaded (old) word.
REQ-026 alu_op in EXEC: add 00000->000010, xor 00100->000101, and 01100->000000, or 01000->000001, min 10000->100000, max 10100->100001, minu 11000->100010, maxu 11100->100011; unlisted funct5 behave as add.
REQ-027 EXEC SHALL last exactly one cycle and latch alu_result as mem_wdata; swap (00001) bypasses ALU, mem_wdata=src.
REQ-028 alu_op SHALL be 000010 outside EXEC.
REQ-029 mem_read held high for all of READ, mem_write for all of WRITE, until mem_ready; never both high.
REQ-030 DONE SHALL last one cycle with done=1, then ->IDLE; start during busy is ignored.
REQ-031 Minimum latency start->done with mem_ready tied high: LR 2, failed SC 1, successful SC 2, AMO 4 cycles.
REQ-032 snoop_valid with snoop_addr[XLEN-1:2] equal to reservation word SHALL clear it; snoop beats a same-cycle LR set.
REQ-033 Own WRITE completion to the reserved word (AMO) SHALL also clear the reservation.

Reset
REQ-034 reset SHALL asynchronously force IDLE and clear reservation, busy, done, mem_read, mem_write, rd_data, mem_wdata, mem_addr to 0, alu_op to 000010.
REQ-035 Reset mid-operation SHALL abandon the op with no further memory request and no done pulse.

Verification
REQ-036 LR @0x100 (mem=0x5), then SC @0x100 src=0x9, mem_ready=1 -> LR done at cycle 2, rd_data=0x5; SC writes 0x9, rd_data=0.
REQ-037 LR @0x100, snoop_valid @0x104 then @0x100, SC @0x100 -> first snoop no effect, second kills; SC rd_data=1, mem_write never asserted.
REQ-038 AMOADD @0x200 (mem=7) src=3, mem_ready=1 -> alu_op=000010 in EXEC, mem_wdata=10, rd_data=7, done at cycle 4.
REQ-039 AMOMINU mem=0xFFFFFFFF src=2, mem_ready delayed 3 cycles per access -> mem_read/mem_write held stable until ready, mem_wdata=2, rd_data=0xFFFFFFFF.
REQ-040 AMOSWAP, assert reset during WRITE -> mem_write drops immediately, no done, busy=0, next start accepted normally.
